// File: rtl/matrix_uart_sender.sv
// -----------------------------------------------------------------------------
// matrix_uart_sender
//
// Formats one display command into ASCII text and streams it to a byte-level
// UART transmitter. Each accepted start renders a value plus mode flags into
// an internal byte buffer, sends the bytes one at a time using the UART busy
// handshake, and then pulses done.
//
// Modes, highest priority first:
//   newline_only : CR LF
//   sum_head     : "TOTAL:" <total> CR LF "|  M|  N|CNT|" CR LF
//   sum_elem     : "|" <value right-aligned in 3> [ "|" CR LF if last column ]
//   id_mode      : <unpadded value> [ CR LF if last column ]
//   element      : <signed value right-aligned in ELEM_FIELD_W>, then CR LF
//                  on the last column or a single space otherwise
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   data          signed value to print
//   start         one-cycle command strobe (accepted only when idle)
//   is_last_col   append the row terminator
//   newline_only  print CR LF only
//   id_mode       print an unpadded decimal ID
//   sum_head      print the summary header, total = data
//   sum_elem      print one summary table cell
//   done          one-cycle pulse after the last byte has left the UART
//   busy          high from the cycle after an accepted start until done
//   tx_data       byte to the UART transmitter
//   tx_start      one-cycle byte strobe to the UART transmitter
//   tx_busy       UART busy, rises the cycle after tx_start
// -----------------------------------------------------------------------------
module matrix_uart_sender #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUF_DEPTH    = 24,
  parameter int ELEM_FIELD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data,
  input  logic                         start,
  input  logic                         is_last_col,
  input  logic                         newline_only,
  input  logic                         id_mode,
  input  logic                         sum_head,
  input  logic                         sum_elem,
  output logic                         done,
  output logic                         busy,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy
);

  // Lengths and pointers are wide enough for any message the formatter can
  // produce, so an oversized message is caught by the assertion below rather
  // than silently wrapping.
  localparam int LEN_W = $clog2(BUF_DEPTH + 8);
  localparam int MAG_W = DATA_WIDTH + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LATCH   = 3'd1;
  localparam logic [2:0] ST_CONV    = 3'd2;
  localparam logic [2:0] ST_BUILD   = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_GUARD   = 3'd5;
  localparam logic [2:0] ST_WAIT_TX = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  localparam logic [2:0] MODE_NL   = 3'd0;
  localparam logic [2:0] MODE_HEAD = 3'd1;
  localparam logic [2:0] MODE_CELL = 3'd2;
  localparam logic [2:0] MODE_ID   = 3'd3;
  localparam logic [2:0] MODE_ELEM = 3'd4;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_BAR   = 8'h7C;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // Fixed header text "TOTAL:".
  function automatic logic [7:0] total_char(input int k);
    case (k)
      0:       return 8'h54;  // T
      1:       return 8'h4F;  // O
      2:       return 8'h54;  // T
      3:       return 8'h41;  // A
      4:       return 8'h4C;  // L
      default: return 8'h3A;  // :
    endcase
  endfunction

  // Fixed table header "|  M|  N|CNT|".
  function automatic logic [7:0] table_char(input int k);
    case (k)
      1, 2, 5, 6:  return CH_SP;
      3:           return 8'h4D;  // M
      7:           return 8'h4E;  // N
      9:           return 8'h43;  // C
      10:          return 8'h4E;  // N
      11:          return 8'h54;  // T
      default:     return CH_BAR;
    endcase
  endfunction

  // Digit slot 0/1/2 = hundreds/tens/ones.
  function automatic logic [7:0] digit_at(input logic [7:0] d_h, input logic [7:0] d_t,
                                          input logic [7:0] d_o, input int s);
    case (s)
      0:       return d_h;
      1:       return d_t;
      default: return d_o;
    endcase
  endfunction

  logic [2:0]            state_q,  state_d;
  logic [2:0]            mode_q,   mode_d;
  logic                  last_q,   last_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  neg_q,    neg_d;
  logic [MAG_W-1:0]      rem_q,    rem_d;
  logic [3:0]            hund_q,   hund_d;
  logic [3:0]            tens_q,   tens_d;
  logic [LEN_W-1:0]      wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]      len_q,    len_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q,  tx_data_d;
  logic [7:0]            buf_q [BUF_DEPTH];

  logic [MAG_W-1:0]      mag;
  logic [7:0]            dig_h, dig_t, dig_o;
  int                    ndig;
  int                    idx;
  int                    rel;
  int                    len_i;
  logic [7:0]            msg_byte;
  logic [LEN_W-1:0]      msg_len;
  logic [7:0]            rd_byte;

  // Magnitude in one extra bit so the most negative value keeps its size
  // (-128 becomes 128). Only elements are treated as signed.
  always_comb begin
    if (mode_q == MODE_ELEM && data_q[DATA_WIDTH-1]) begin
      mag = (~{1'b1, data_q}) + 1'b1;
    end else begin
      mag = {1'b0, data_q};
    end
  end

  // Digit characters and the unpadded digit count (zero prints one digit).
  always_comb begin
    dig_h = CH_ZERO + {4'h0, hund_q};
    dig_t = CH_ZERO + {4'h0, tens_q};
    dig_o = CH_ZERO + {4'h0, rem_q[3:0]};
    if (hund_q != 4'd0) begin
      ndig = 3;
    end else if (tens_q != 4'd0) begin
      ndig = 2;
    end else begin
      ndig = 1;
    end
  end

  // Byte generator: the character at buffer position wr_idx_q for the
  // latched mode, plus the total message length.
  always_comb begin
    idx      = int'(wr_idx_q);
    rel      = 0;
    msg_byte = CH_SP;
    len_i    = 2;
    case (mode_q)
      MODE_NL: begin
        len_i    = 2;
        msg_byte = (idx == 0) ? CH_CR : CH_LF;
      end
      MODE_HEAD: begin
        len_i = 6 + ndig + 17;
        rel   = idx - 6 - ndig;
        if (idx < 6) begin
          msg_byte = total_char(idx);
        end else if (rel < 0) begin
          msg_byte = digit_at(dig_h, dig_t, dig_o, idx - 3 - ndig);
        end else if (rel == 0 || rel == 15) begin
          msg_byte = CH_CR;
        end else if (rel == 1 || rel == 16) begin
          msg_byte = CH_LF;
        end else begin
          msg_byte = table_char(rel - 2);
        end
      end
      MODE_CELL: begin
        len_i = last_q ? 7 : 4;
        if (idx == 0 || idx == 4) begin
          msg_byte = CH_BAR;
        end else if (idx <= 3) begin
          // Positions 1..3 map onto hundreds/tens/ones; leading slots blank.
          msg_byte = (idx - 1 >= 3 - ndig) ? digit_at(dig_h, dig_t, dig_o, idx - 1) : CH_SP;
        end else begin
          msg_byte = (idx == 5) ? CH_CR : CH_LF;
        end
      end
      MODE_ID: begin
        len_i = ndig + (last_q ? 2 : 0);
        if (idx < ndig) begin
          msg_byte = digit_at(dig_h, dig_t, dig_o, idx + 3 - ndig);
        end else begin
          msg_byte = (idx == ndig) ? CH_CR : CH_LF;
        end
      end
      default: begin
        len_i = ELEM_FIELD_W + (last_q ? 2 : 1);
        if (idx >= ELEM_FIELD_W) begin
          msg_byte = !last_q ? CH_SP : ((idx == ELEM_FIELD_W) ? CH_CR : CH_LF);
        end else if (idx >= ELEM_FIELD_W - ndig) begin
          msg_byte = digit_at(dig_h, dig_t, dig_o, idx - ELEM_FIELD_W + 3);
        end else if (neg_q && idx == ELEM_FIELD_W - ndig - 1) begin
          // The sign hugs the first digit, padding goes in front of it.
          msg_byte = CH_MINUS;
        end else begin
          msg_byte = CH_SP;
        end
      end
    endcase
    msg_len = LEN_W'(len_i);
  end

  assign rd_byte = (rd_ptr_q < LEN_W'(BUF_DEPTH)) ? buf_q[rd_ptr_q] : 8'h00;

  // Next-state logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    last_d     = last_q;
    data_d     = data_q;
    neg_d      = neg_q;
    rem_d      = rem_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    wr_idx_d   = wr_idx_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Inputs are captured on the accept cycle; later changes are ignored.
          data_d = data;
          last_d = is_last_col;
          if (newline_only) begin
            mode_d = MODE_NL;
          end else if (sum_head) begin
            mode_d = MODE_HEAD;
          end else if (sum_elem) begin
            mode_d = MODE_CELL;
          end else if (id_mode) begin
            mode_d = MODE_ID;
          end else begin
            mode_d = MODE_ELEM;
          end
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        neg_d    = (mode_q == MODE_ELEM) && data_q[DATA_WIDTH-1];
        rem_d    = mag;
        hund_d   = 4'd0;
        tens_d   = 4'd0;
        wr_idx_d = '0;
        state_d  = (mode_q == MODE_NL) ? ST_BUILD : ST_CONV;
      end
      ST_CONV: begin
        // One subtraction per cycle; the ones digit is what remains.
        if (rem_q >= MAG_W'(100)) begin
          rem_d  = rem_q - MAG_W'(100);
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= MAG_W'(10)) begin
          rem_d  = rem_q - MAG_W'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = ST_BUILD;
        end
      end
      ST_BUILD: begin
        len_d = msg_len;
        if (wr_idx_q == msg_len - 1'b1) begin
          rd_ptr_d = '0;
          state_d  = ST_SEND;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = rd_byte;
          state_d    = ST_GUARD;
        end
      end
      ST_GUARD: begin
        // The UART raises tx_busy only after it has seen tx_start, so its
        // busy flag is not yet meaningful in this cycle.
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (!tx_busy) begin
          if (rd_ptr_q == len_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ELEM;
      last_q     <= 1'b0;
      data_q     <= '0;
      neg_q      <= 1'b0;
      rem_q      <= '0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      wr_idx_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous cycle, independent of statement order.
      state_q    <= state_d;
      mode_q     <= mode_d;
      last_q     <= last_d;
      data_q     <= data_d;
      neg_q      <= neg_d;
      rem_q      <= rem_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      wr_idx_q   <= wr_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // NOTE: the byte buffer has no reset; every entry is written in BUILD
  // before SEND reads it, so clearing it would only cost hardware.
  always_ff @(posedge clk) begin
    if (state_q == ST_BUILD && wr_idx_q < LEN_W'(BUF_DEPTH)) begin
      buf_q[wr_idx_q] <= msg_byte;
    end
  end

  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  // A summary header with a two- or three-digit total needs 25-26 bytes;
  // BUF_DEPTH must be raised if such totals are ever printed.
  len_fits_buffer: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_BUILD) |-> (msg_len <= LEN_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_matrix_uart_sender.sv
// -----------------------------------------------------------------------------
// tb_matrix_uart_sender
//
// Directed bench for matrix_uart_sender. Stimulus pushes the hand-written
// expected byte stream of each command into exp_q; a monitor pops and compares
// on every tx_start. A simple UART model holds tx_busy for uart_len cycles
// after each tx_start.
// -----------------------------------------------------------------------------
module tb_matrix_uart_sender;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] data;
  logic              start;
  logic              is_last_col;
  logic              newline_only;
  logic              id_mode;
  logic              sum_head;
  logic              sum_elem;
  logic              done;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  always #5 clk = ~clk;

  matrix_uart_sender #(
    .DATA_WIDTH  (8),
    .BUF_DEPTH   (24),
    .ELEM_FIELD_W(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .start       (start),
    .is_last_col (is_last_col),
    .newline_only(newline_only),
    .id_mode     (id_mode),
    .sum_head    (sum_head),
    .sum_elem    (sum_elem),
    .done        (done),
    .busy        (busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
  );

  int         checks     = 0;
  int         errors     = 0;
  int         tx_count   = 0;
  int         done_count = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  // UART model: busy from the cycle after tx_start for uart_len cycles.
  int uart_len = 10;
  int uart_cnt = 0;
  assign tx_busy = (uart_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) uart_cnt <= uart_len;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      tx_count++;
      check("tx_start_vs_tx_busy", {31'b0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: actual=0x%0h required=none", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte", {24'b0, tx_data}, {24'b0, exp_b});
      end
    end
    if (rst_n && done) done_count++;
  end

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic expect_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic issue(input logic [7:0] d, input logic last, input logic nl,
                       input logic sh, input logic se, input logic idm);
    @(negedge clk); #1;
    data = d; is_last_col = last; newline_only = nl;
    sum_head = sh; sum_elem = se; id_mode = idm; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: the command must already be latched.
    data = ~d; is_last_col = ~last; newline_only = ~nl;
    sum_head = ~sh; sum_elem = ~se; id_mode = ~idm;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input bit coincident);
    int  base;
    bit  seen;
    base = done_count;
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: actual=no done required=done", name);
    end else begin
      check({name, "_done_once"}, done_count - base, 32'd1);
      check({name, "_bytes_left"}, exp_q.size(), 32'd0);
      check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
      if (coincident) begin
        newline_only = 1'b1; sum_head = 1'b0; start = 1'b1;
      end
      @(negedge clk); #1;
      start = 1'b0;
      check({name, "_done_pulse_len"}, {31'b0, done}, 32'd0);
      check({name, "_idle_after_done"}, {31'b0, busy}, 32'd0);
    end
    newline_only = 1'b0; sum_head = 1'b0; sum_elem = 1'b0; id_mode = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [7:0] d, input logic last,
                         input logic nl, input logic sh, input logic se, input logic idm,
                         input bit repulse, input bit coincident);
    int tbase;
    int n;
    tbase = tx_count;
    n     = exp_q.size();
    issue(d, last, nl, sh, se, idm);
    if (repulse) begin
      repeat (4) @(negedge clk);
      #1;
      newline_only = 1'b1; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0; newline_only = 1'b0;
      check({name, "_busy_through_repulse"}, {31'b0, busy}, 32'd1);
    end
    wait_done(name, coincident);
    check({name, "_tx_count"}, tx_count - tbase, n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  tbase;
    int  dbase;
    bit  found;

    rst_n = 1'b0; start = 1'b0; data = '0; is_last_col = 1'b0;
    newline_only = 1'b0; id_mode = 1'b0; sum_head = 1'b0; sum_elem = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'b0, tx_data},  32'd0);
    rst_n = 1'b1;

    // Reset while the third byte of a summary header is being launched.
    expect_str("TOTAL:3"); expect_crlf(); expect_str("|  M|  N|CNT|"); expect_crlf();
    tbase = tx_count;
    issue(8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (tx_start && tx_count == tbase + 3) begin found = 1'b1; break; end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reset_third_byte_timeout: actual=not seen required=third tx_start");
    end
    dbase = done_count;
    rst_n = 1'b0;
    #1;
    check("reset_async_tx_start", {31'b0, tx_start}, 32'd0);
    check("reset_async_busy",     {31'b0, busy},     32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("reset_no_done", done_count - dbase, 32'd0);
    check("reset_stays_idle", {31'b0, busy}, 32'd0);

    // Elements.
    uart_len = 10;
    expect_str("-128 ");
    run_cmd("elem_m128", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    uart_len = 3;
    expect_str("   5"); expect_crlf();
    run_cmd("elem_5_last", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_str("  -7 ");
    run_cmd("elem_m7", 8'hF9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Summary header and one table row, with a start coincident with done.
    expect_str("TOTAL:3"); expect_crlf(); expect_str("|  M|  N|CNT|"); expect_crlf();
    run_cmd("sum_head_3", 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_str("|  2");
    run_cmd("cell_2", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_str("|  3");
    run_cmd("cell_3", 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_str("|  1|"); expect_crlf();
    run_cmd("cell_1_last", 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // IDs and newlines, including mode priority.
    expect_str("25"); expect_crlf();
    run_cmd("id_25_last", 8'd25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_crlf();
    run_cmd("nl_ff", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_crlf();
    run_cmd("nl_over_head", 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start re-pulsed while busy must not queue a second command.
    uart_len = 10;
    expect_str(" 127 ");
    run_cmd("elem_127_repulse", 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Boundary values.
    uart_len = 2;
    expect_str("0");
    run_cmd("id_0", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_str("|100|"); expect_crlf();
    run_cmd("cell_100_last", 8'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_str("   0"); expect_crlf();
    run_cmd("elem_0_last", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_str("200");
    run_cmd("id_200", 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_idle", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
